// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of a single-cycle RV32 R-type ALU.
// One registered result slot; a new operation is accepted whenever that slot is free or draining.
module alu_issue_arbiter #(
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_instr,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_instr,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_src,
    output logic        res_illegal,
    output logic [15:0] issue_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Producers hold valid and payload until accepted; ready never looks at the payload.

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic RR_INIT_B = (RR_INIT != 0);

    state_t      state;
    logic        last_grant;
    logic        space;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        sel;
    logic [31:0] sel_instr;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        legal;
    logic [4:0]  shamt;
    logic [31:0] alu_out;
    logic        unused_instr_bits;

    assign res_valid = (state == FULL);
    assign space     = (state == EMPTY) || res_ready;

    // On a tie the requester that did not win last time goes first.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = grant0 && space && !rst;
    assign req1_ready = grant1 && space && !rst;
    assign accept     = req0_ready || req1_ready;

    assign sel       = grant1;
    assign sel_instr = sel ? req1_instr : req0_instr;
    assign sel_a     = sel ? req1_a : req0_a;
    assign sel_b     = sel ? req1_b : req0_b;

    assign funct7 = sel_instr[31:25];
    assign funct3 = sel_instr[14:12];
    assign op     = {sel_instr[30], funct3};
    assign shamt  = sel_b[4:0];
    assign legal  = (sel_instr[6:0] == 7'b0110011) &&
                    ((funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));

    // Register and rd fields play no part in the computation.
    assign unused_instr_bits = ^{sel_instr[24:15], sel_instr[11:7]};

    always_comb begin
        alu_out = 32'h0;
        case (op)
            4'b0000: alu_out = sel_a + sel_b;
            4'b1000: alu_out = sel_a - sel_b;
            4'b0001: alu_out = sel_a << shamt;
            4'b0010: alu_out = {31'h0, $signed(sel_a) < $signed(sel_b)};
            4'b0011: alu_out = {31'h0, sel_a < sel_b};
            4'b0100: alu_out = sel_a ^ sel_b;
            4'b0101: alu_out = sel_a >> shamt;
            4'b1101: alu_out = $unsigned($signed(sel_a) >>> shamt);
            4'b0110: alu_out = sel_a | sel_b;
            4'b0111: alu_out = sel_a & sel_b;
            default: alu_out = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            res_data    <= 32'h0;
            res_src     <= 1'b0;
            res_illegal <= 1'b0;
            issue_cnt   <= 16'h0;
            last_grant  <= ~RR_INIT_B;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (res_ready && !accept) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                res_data    <= legal ? alu_out : 32'h0;
                res_src     <= sel;
                res_illegal <= !legal;
                last_grant  <= sel;
                issue_cnt   <= issue_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: ALU vector table, then contention,
// backpressure, reset and counter-wrap sequences.
module tb_alu_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_instr, req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_instr, req1_a, req1_b;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_src, res_illegal;
    logic [15:0] issue_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_cnt;
    logic [32:0] exp_q[$];
    logic [32:0] exp_item;

    alu_issue_arbiter #(.RR_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_instr(req0_instr), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_instr(req1_instr), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_src(res_src), .res_illegal(res_illegal),
        .issue_cnt(issue_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        exp_cnt = 16'h0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // drivers: present one op on requester `src`, random junk on the other
    task automatic drive(input logic src, input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b);
        req0_valid = (src == 1'b0);
        req1_valid = (src == 1'b1);
        req0_instr = src ? $urandom : instr;
        req0_a     = src ? $urandom : a;
        req0_b     = src ? $urandom : b;
        req1_instr = src ? instr : $urandom;
        req1_a     = src ? a : $urandom;
        req1_b     = src ? b : $urandom;
    endtask

    typedef struct {
        logic        src;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1'b0, rtype(7'h00, 3'd0), 32'd7,        32'd5,        32'd12,        1'b0};
        vecs[1]  = '{1'b1, rtype(7'h20, 3'd0), 32'd3,        32'd5,        32'hFFFFFFFE,  1'b0};
        vecs[2]  = '{1'b0, rtype(7'h20, 3'd5), 32'h80000000, 32'd4,        32'hF8000000,  1'b0};
        vecs[3]  = '{1'b1, rtype(7'h00, 3'd5), 32'h80000000, 32'd4,        32'h08000000,  1'b0};
        vecs[4]  = '{1'b0, rtype(7'h00, 3'd2), 32'hFFFFFFFF, 32'd1,        32'd1,         1'b0};
        vecs[5]  = '{1'b0, rtype(7'h00, 3'd3), 32'hFFFFFFFF, 32'd1,        32'd0,         1'b0};
        vecs[6]  = '{1'b1, rtype(7'h00, 3'd1), 32'd1,        32'h21,       32'd2,         1'b0};
        vecs[7]  = '{1'b0, rtype(7'h00, 3'd4), 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0,  1'b0};
        vecs[8]  = '{1'b1, rtype(7'h00, 3'd6), 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0,  1'b0};
        vecs[9]  = '{1'b0, rtype(7'h00, 3'd7), 32'h0000F0F0, 32'h0000FF00, 32'h0000F000,  1'b0};
        vecs[10] = '{1'b0, 32'h00208193,       32'd7,        32'd5,        32'd0,         1'b1};
        vecs[11] = '{1'b1, rtype(7'h30, 3'd0), 32'd7,        32'd5,        32'd0,         1'b1};
        vecs[12] = '{1'b0, rtype(7'h20, 3'd1), 32'd7,        32'd5,        32'd0,         1'b1};
        vecs[13] = '{1'b1, rtype(7'h00, 3'd0), 32'hFFFFFFFF, 32'd1,        32'd0,         1'b0};
        vecs[14] = '{1'b0, rtype(7'h20, 3'd5), 32'h7FFFFFF0, 32'd36,       32'h07FFFFFF,  1'b0};

        // reset state, with requests pending during reset
        rst = 1'b1;
        res_ready = 1'b1;
        drive(1'b0, rtype(7'h00, 3'd0), 32'd1, 32'd1);
        req1_valid = 1'b1;
        #1;
        chk("rst_ready0", {31'h0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'h0, req1_ready}, 32'd0);
        tick();
        tick();
        chk("rst_valid",   {31'h0, res_valid},   32'd0);
        chk("rst_data",    res_data,             32'd0);
        chk("rst_src",     {31'h0, res_src},     32'd0);
        chk("rst_illegal", {31'h0, res_illegal}, 32'd0);
        chk("rst_cnt",     {16'h0, issue_cnt},   32'd0);
        do_reset();

        // table of single issues with the consumer always ready
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].src, vecs[i].instr, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("v%0d_ready0", i), {31'h0, req0_ready}, {31'h0, vecs[i].src == 1'b0});
            chk($sformatf("v%0d_ready1", i), {31'h0, req1_ready}, {31'h0, vecs[i].src == 1'b1});
            tick();
            exp_cnt = exp_cnt + 16'd1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            chk($sformatf("v%0d_valid", i),   {31'h0, res_valid},   32'd1);
            chk($sformatf("v%0d_data", i),    res_data,             vecs[i].exp_data);
            chk($sformatf("v%0d_src", i),     {31'h0, res_src},     {31'h0, vecs[i].src});
            chk($sformatf("v%0d_illegal", i), {31'h0, res_illegal}, {31'h0, vecs[i].exp_ill});
            chk($sformatf("v%0d_cnt", i),     {16'h0, issue_cnt},   {16'h0, exp_cnt});
        end
        tick();
        chk("drain_valid", {31'h0, res_valid}, 32'd0);

        // contention: both valid, alternation starting from requester 0
        do_reset();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_instr = rtype(7'h00, 3'd0); req0_a = 32'd10; req0_b = 32'd1;
        req1_valid = 1'b1; req1_instr = rtype(7'h00, 3'd0); req1_a = 32'd20; req1_b = 32'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_ready0", k), {31'h0, req0_ready}, {31'h0, (k % 2) == 0});
            chk($sformatf("rr%0d_ready1", k), {31'h0, req1_ready}, {31'h0, (k % 2) == 1});
            exp_q.push_back(((k % 2) == 0) ? {1'b0, 32'd11} : {1'b1, 32'd22});
            tick();
            exp_cnt = exp_cnt + 16'd1;
            exp_item = exp_q.pop_front();
            chk($sformatf("rr%0d_src", k),  {31'h0, res_src},   {31'h0, exp_item[32]});
            chk($sformatf("rr%0d_data", k), res_data,           exp_item[31:0]);
            chk($sformatf("rr%0d_cnt", k),  {16'h0, issue_cnt}, {16'h0, exp_cnt});
        end

        // backpressure: hold a result of 12 while both requesters wait
        do_reset();
        drive(1'b0, rtype(7'h00, 3'd0), 32'd7, 32'd5);
        tick();
        chk("bp_data0", res_data, 32'd12);
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_instr = rtype(7'h00, 3'd0); req1_a = 32'd2; req1_b = 32'd2;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_ready0", k), {31'h0, req0_ready}, 32'd0);
            chk($sformatf("bp%0d_ready1", k), {31'h0, req1_ready}, 32'd0);
            tick();
            chk($sformatf("bp%0d_valid", k), {31'h0, res_valid}, 32'd1);
            chk($sformatf("bp%0d_data", k),  res_data,           32'd12);
            chk($sformatf("bp%0d_src", k),   {31'h0, res_src},   32'd0);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_resume_ready0", {31'h0, req0_ready}, 32'd0);
        chk("bp_resume_ready1", {31'h0, req1_ready}, 32'd1);
        tick();
        chk("bp_resume_data", res_data,           32'd4);
        chk("bp_resume_src",  {31'h0, res_src},   32'd1);
        chk("bp_resume_cnt",  {16'h0, issue_cnt}, 32'd2);

        // reset while a result is pending: it must never be delivered
        res_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready0", {31'h0, req0_ready}, 32'd0);
        chk("mid_rst_ready1", {31'h0, req1_ready}, 32'd0);
        tick();
        chk("mid_rst_valid", {31'h0, res_valid}, 32'd0);
        chk("mid_rst_cnt",   {16'h0, issue_cnt}, 32'd0);
        chk("mid_rst_data",  res_data,           32'd0);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("mid_rst_after_valid", {31'h0, res_valid}, 32'd0);

        // counter wrap: 65535 accepts reach FFFF, the next one wraps to 0
        do_reset();
        drive(1'b0, rtype(7'h00, 3'd0), 32'd7, 32'd5);
        res_ready = 1'b1;
        repeat (65535) tick();
        chk("wrap_cnt_ffff", {16'h0, issue_cnt}, 32'h0000FFFF);
        chk("wrap_valid",    {31'h0, res_valid}, 32'd1);
        tick();
        chk("wrap_cnt_zero", {16'h0, issue_cnt}, 32'd0);
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("wrap_rst_valid", {31'h0, res_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
